mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: RA_CODE, 2'b10, RegDst code selecting $31 at the write-address mux.
REQ-002 Parameter: RD_CODE, 2'b01, RegDst code selecting rd; rt is always 2'b00.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-005 opcode  input  6  IR[31:26], stable from end of IF until next IF.
REQ-006 funct  input  6  IR[5:0].
REQ-007 zero  input  1  ALU equality flag, valid in EX.
REQ-008 PCWrite  output  1  PC load enable.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 RegWrite  output  1  GRF write enable.
REQ-011 MemWrite  output  1  DM write enable.
REQ-012 RegDst  output  2  write-address mux select: 00 rt, RD_CODE rd, RA_CODE $31.
REQ-013 MemtoReg  output  2  write-data select: 00 ALU, 01 DM, 10 PC+4.
REQ-014 ALUSrc  output  1  0 register, 1 extended immediate.
REQ-015 ALUOp  output  3  000 add, 001 sub, 010 or, 011 lui-shift.
REQ-016 ExtOp  output  1  0 zero-extend, 1 sign-extend.
REQ-017 PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs.
REQ-018 state  output  3  current FSM state, for debug.
REQ-019 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-020 FSM states SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF next cycle with all enables 0.
REQ-021 Supported: addu(00/21), subu(00/23), ori(0d), lui(0f), lw(23), sw(2b), beq(04), jal(03), jr(00/08).
REQ-022 Sequences: addu/subu/ori/lui IF-ID-EX-WB; lw IF-ID-EX-MEM-WB; sw IF-ID-EX-MEM; beq IF-ID-EX; jr IF-ID-EX; jal IF-ID-WB.
REQ-023 IF SHALL assert IRWrite=1, PCWrite=1, PCSrc=00; all other enables 0.
REQ-024 ID SHALL assert no enables; decode SHALL be combinational from opcode/funct.
REQ-025 beq EX: PCWrite=zero, PCSrc=01, ALUOp=001; instr_done=1.
REQ-026 jr EX: PCWrite=1, PCSrc=11; instr_done=1.
REQ-027 jal WB: RegWrite=1, RegDst=RA_CODE, MemtoReg=10, PCWrite=1, PCSrc=10; instr_done=1.
REQ-028 sw MEM: MemWrite=1, ALUSrc=1, ExtOp=1; instr_done=1.
REQ-029 R-type WB: RegWrite=1, RegDst=RD_CODE, MemtoReg=00; lw WB: RegDst=00, MemtoReg=01; ori/lui WB: RegDst=00, MemtoReg=00.
REQ-030 ALUSrc/ALUOp/ExtOp SHALL be held at the instruction's values in EX, MEM and WB.
REQ-031 Unsupported opcode/funct SHALL return ID->IF with no write enable, PCWrite or instr_done asserted (NOP).
REQ-032 RegWrite, MemWrite and PCWrite SHALL each be high at most one cycle per instruction, except PCWrite, which is also high in IF.
REQ-033 Outputs SHALL be Moore-style functions of state and decode; zero SHALL affect only PCWrite in beq EX.

Reset
REQ-034 reset high at a clk edge SHALL force state=IF on that edge, overriding any transition.
REQ-035 While reset is high, all enables, instr_done, RegDst, MemtoReg and PCSrc SHALL be 0.
REQ-036 Reset mid-instruction SHALL abandon it with no further write; the first post-reset cycle is IF.

Verification
REQ-037 reset 2 cycles, then opcode=00 funct=21 -> states 0,1,2,4; in WB RegWrite=1, RegDst=01; instr_done only in WB.
REQ-038 opcode=23 (lw) -> states 0,1,2,3,4; WB RegDst=00, MemtoReg=01; MemWrite stays 0 throughout.
REQ-039 opcode=04 with zero=1, then zero=0 -> PCWrite=1, PCSrc=01 in EX for the first; PCWrite=0 in EX for the second; both 3 cycles.
REQ-040 opcode=03 (jal) -> states 0,1,4; WB RegDst=10, MemtoReg=10, PCSrc=10, RegWrite=1.
REQ-041 opcode=3f -> states 0,1,0; no enable except IRWrite/PCWrite in IF; instr_done=0.
REQ-042 reset asserted in MEM of sw -> MemWrite=0 that cycle; state=0 next cycle; then a normal fetch.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: five-state Moore FSM (IF/ID/EX/MEM/WB)
// with combinational instruction decode from opcode/funct.
module mc_ctrl #(
    parameter logic [1:0] RA_CODE = 2'b10,
    parameter logic [1:0] RD_CODE = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic       ExtOp,
    output logic [1:0] PCSrc,
    output logic [2:0] state,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        InsNop,
        InsAddu,
        InsSubu,
        InsOri,
        InsLui,
        InsLw,
        InsSw,
        InsBeq,
        InsJal,
        InsJr
    } ins_e;

    state_e     state_q, state_d;
    ins_e       ins;
    logic       alu_src_dec;
    logic [2:0] alu_op_dec;
    logic       ext_op_dec;

    // Instruction decode; anything not recognised is treated as a NOP.
    always_comb begin
        ins = InsNop;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   ins = InsAddu;
                    6'h23:   ins = InsSubu;
                    6'h08:   ins = InsJr;
                    default: ins = InsNop;
                endcase
            end
            6'h0d:   ins = InsOri;
            6'h0f:   ins = InsLui;
            6'h23:   ins = InsLw;
            6'h2b:   ins = InsSw;
            6'h04:   ins = InsBeq;
            6'h03:   ins = InsJal;
            default: ins = InsNop;
        endcase
    end

    // ALU/extender controls per instruction, presented only from EX onwards.
    always_comb begin
        alu_src_dec = 1'b0;
        alu_op_dec  = 3'b000;
        ext_op_dec  = 1'b0;
        case (ins)
            InsSubu: alu_op_dec = 3'b001;
            InsOri: begin
                alu_src_dec = 1'b1;
                alu_op_dec  = 3'b010;
            end
            InsLui: begin
                alu_src_dec = 1'b1;
                alu_op_dec  = 3'b011;
            end
            InsLw, InsSw: begin
                alu_src_dec = 1'b1;
                ext_op_dec  = 1'b1;
            end
            InsBeq: begin
                alu_op_dec = 3'b001;
                ext_op_dec = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state selection; unused encodings fall back to IF.
    always_comb begin
        state_d = StIf;
        case (state_q)
            StIf: state_d = StId;
            StId: begin
                if (ins == InsNop) begin
                    state_d = StIf;
                end else if (ins == InsJal) begin
                    state_d = StWb;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                case (ins)
                    InsAddu, InsSubu, InsOri, InsLui: state_d = StWb;
                    InsLw, InsSw:                     state_d = StMem;
                    default:                          state_d = StIf;
                endcase
            end
            StMem:   state_d = (ins == InsLw) ? StWb : StIf;
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    // State register with synchronous reset that overrides any transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Moore outputs; reset forces every control to its idle value at once so
    // an in-flight write is dropped in the very cycle reset is seen.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUSrc     = 1'b0;
        ALUOp      = 3'b000;
        ExtOp      = 1'b0;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                StIf: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = 2'b00;
                end
                StId: ;
                StEx: begin
                    ALUSrc = alu_src_dec;
                    ALUOp  = alu_op_dec;
                    ExtOp  = ext_op_dec;
                    case (ins)
                        InsBeq: begin
                            PCWrite    = zero;
                            PCSrc      = 2'b01;
                            instr_done = 1'b1;
                        end
                        InsJr: begin
                            PCWrite    = 1'b1;
                            PCSrc      = 2'b11;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    ALUSrc = alu_src_dec;
                    ALUOp  = alu_op_dec;
                    ExtOp  = ext_op_dec;
                    if (ins == InsSw) begin
                        MemWrite   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                StWb: begin
                    ALUSrc = alu_src_dec;
                    ALUOp  = alu_op_dec;
                    ExtOp  = ext_op_dec;
                    case (ins)
                        InsAddu, InsSubu: begin
                            RegWrite   = 1'b1;
                            RegDst     = RD_CODE;
                            instr_done = 1'b1;
                        end
                        InsOri, InsLui: begin
                            RegWrite   = 1'b1;
                            instr_done = 1'b1;
                        end
                        InsLw: begin
                            RegWrite   = 1'b1;
                            MemtoReg   = 2'b01;
                            instr_done = 1'b1;
                        end
                        InsJal: begin
                            RegWrite   = 1'b1;
                            RegDst     = RA_CODE;
                            MemtoReg   = 2'b10;
                            PCWrite    = 1'b1;
                            PCSrc      = 2'b10;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a driver issues instructions (directed, then
// random) and pushes the expected per-cycle control vectors; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_mc_ctrl;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_JAL  = 7;
    localparam int K_JR   = 8;
    localparam int K_BAD  = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       asrc;
        logic [2:0] aop;
        logic       ext;
        logic [1:0] pcsrc;
        logic       done;
    } exp_t;

    typedef struct {
        exp_t  v;
        string tag;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, ExtOp, instr_done;
    logic [1:0] RegDst, MemtoReg, PCSrc;
    logic [2:0] ALUOp, state;

    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;
    exp_t act;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
        .ExtOp      (ExtOp),
        .PCSrc      (PCSrc),
        .state      (state),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    assign act = '{st: state, pcw: PCWrite, irw: IRWrite, rw: RegWrite, mw: MemWrite,
                   rdst: RegDst, m2r: MemtoReg, asrc: ALUSrc, aop: ALUOp, ext: ExtOp,
                   pcsrc: PCSrc, done: instr_done};

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%05h required=%05h (st %0d vs %0d)",
                         e.tag, act, e.v, act.st, e.v.st);
            end
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_ADDU:  return "addu";
            K_SUBU:  return "subu";
            K_ORI:   return "ori";
            K_LUI:   return "lui";
            K_LW:    return "lw";
            K_SW:    return "sw";
            K_BEQ:   return "beq";
            K_JAL:   return "jal";
            K_JR:    return "jr";
            default: return "nop";
        endcase
    endfunction

    // Reference model: an instruction is a list of visited states; IF always
    // fetches, EX/MEM/WB carry the instruction's ALU setup, and the final cycle
    // commits the instruction's architectural effect.
    task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                             input logic [15:0] zb, input int abort);
        int   sts[$];
        exp_t e;
        logic asrc;
        logic [2:0] aop;
        logic ext;
        int   n;
        case (kind)
            K_ADDU, K_SUBU, K_ORI, K_LUI: sts = {0, 1, 2, 4};
            K_LW:                         sts = {0, 1, 2, 3, 4};
            K_SW:                         sts = {0, 1, 2, 3};
            K_BEQ, K_JR:                  sts = {0, 1, 2};
            K_JAL:                        sts = {0, 1, 4};
            default:                      sts = {0, 1};
        endcase
        {asrc, aop, ext} = 5'b0;
        case (kind)
            K_SUBU:     aop = 3'd1;
            K_ORI:      {asrc, aop} = {1'b1, 3'd2};
            K_LUI:      {asrc, aop} = {1'b1, 3'd3};
            K_LW, K_SW: {asrc, ext} = 2'b11;
            K_BEQ:      {aop, ext} = {3'd1, 1'b1};
            default: ;
        endcase
        n = (abort >= 0 && abort < sts.size()) ? abort + 1 : sts.size();
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.st = sts[i][2:0];
            if (i == abort) begin
                // reset seen this cycle: state still visible, everything else idle
            end else begin
                if (sts[i] == 0) {e.irw, e.pcw} = 2'b11;
                if (sts[i] >= 2) {e.asrc, e.aop, e.ext} = {asrc, aop, ext};
                if (i == sts.size() - 1 && kind != K_BAD) begin
                    e.done = 1'b1;
                    case (kind)
                        K_ADDU, K_SUBU: {e.rw, e.rdst} = {1'b1, 2'b01};
                        K_ORI, K_LUI:   e.rw = 1'b1;
                        K_LW:           {e.rw, e.m2r} = {1'b1, 2'b01};
                        K_SW:           e.mw = 1'b1;
                        K_BEQ:          {e.pcw, e.pcsrc} = {zb[i], 2'b01};
                        K_JR:           {e.pcw, e.pcsrc} = {1'b1, 2'b11};
                        K_JAL: begin
                            {e.rw, e.rdst, e.m2r} = {1'b1, 2'b10, 2'b10};
                            {e.pcw, e.pcsrc} = {1'b1, 2'b10};
                        end
                        default: ;
                    endcase
                end
            end
            sbq.push_back('{v: e, tag: $sformatf("%s op=%02h c%0d", kname(kind), op, i)});
        end
        opcode = op;
        funct  = fn;
        for (int i = 0; i < n; i++) begin
            zero = zb[i];
            if (i == abort) reset = 1'b1;
            @(posedge clk);
            #1;
            if (i == abort) reset = 1'b0;
        end
    endtask

    task automatic rand_instr();
        int         kind;
        logic [5:0] op, fn;
        int         abort;
        kind = $urandom_range(0, 9);
        fn = 6'($urandom);
        case (kind)
            K_ADDU:  {op, fn} = {6'h00, 6'h21};
            K_SUBU:  {op, fn} = {6'h00, 6'h23};
            K_JR:    {op, fn} = {6'h00, 6'h08};
            K_ORI:   op = 6'h0d;
            K_LUI:   op = 6'h0f;
            K_LW:    op = 6'h23;
            K_SW:    op = 6'h2b;
            K_BEQ:   op = 6'h04;
            K_JAL:   op = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    op = 6'h00;
                    while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'($urandom);
                end else begin
                    op = 6'($urandom);
                    while (op == 6'h00 || op == 6'h0d || op == 6'h0f || op == 6'h23 ||
                           op == 6'h2b || op == 6'h04 || op == 6'h03) op = 6'($urandom);
                end
            end
        endcase
        abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
        run_instr(kind, op, fn, 16'($urandom), abort);
    endtask

    // Driver: reset, directed sequences, then random traffic.
    initial begin
        @(posedge clk);
        #1;
        sbq.push_back('{v: '0, tag: "reset"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(K_ADDU, 6'h00, 6'h21, 16'h0000, -1);
        run_instr(K_LW, 6'h23, 6'h15, 16'hffff, -1);
        run_instr(K_BEQ, 6'h04, 6'h00, 16'h0004, -1);
        run_instr(K_BEQ, 6'h04, 6'h00, 16'hfffb, -1);
        run_instr(K_JAL, 6'h03, 6'h21, 16'hffff, -1);
        run_instr(K_BAD, 6'h3f, 6'h00, 16'hffff, -1);
        run_instr(K_SW, 6'h2b, 6'h00, 16'h0000, 3);
        run_instr(K_ADDU, 6'h00, 6'h21, 16'h0000, -1);
        run_instr(K_ORI, 6'h0d, 6'h00, 16'h0000, -1);
        run_instr(K_LUI, 6'h0f, 6'h00, 16'h0000, -1);
        run_instr(K_JR, 6'h00, 6'h08, 16'h0000, -1);
        run_instr(K_SUBU, 6'h00, 6'h23, 16'h0000, -1);
        for (int i = 0; i < 300; i++) rand_instr();
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
